// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter merging NUM_REQ valid/ready producers
// onto a single FIFO write port. A winner keeps the port for up to BURST_LEN
// beats, then the pointer advances past it. Writes are throttled by fifo_full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               state_r;
  logic [PTR_W-1:0]     owner_r;
  logic [PTR_W-1:0]     rr_ptr_r;
  logic [CNT_W-1:0]     beat_cnt_r;
  logic [NUM_REQ-1:0]   grant_r;
  logic                 busy_r;

  logic                  pick_found_s;
  logic [PTR_W-1:0]      pick_idx_s;
  logic                  owner_valid_s;
  logic [DATA_WIDTH-1:0] owner_data_s;
  logic                  last_beat_s;
  logic [PTR_W-1:0]      next_ptr_s;

  // Index to one-hot conversion for the grant vector.
  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == PTR_W'(i)) begin
        vec[i] = 1'b1;
      end else begin
        vec[i] = 1'b0;
      end
    end
    return vec;
  endfunction

  // Round-robin search: first valid requester at or after rr_ptr, wrapping by compare.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    sum          = '0;
    cand         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_r} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end else begin
        sum = sum;
      end
      cand = sum[PTR_W-1:0];
      if (!pick_found_s && req_valid[cand]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Owner's valid/data selection and the combinational handshake/write outputs.
  always_comb begin
    owner_valid_s = 1'b0;
    owner_data_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_r == PTR_W'(i)) begin
        owner_valid_s = req_valid[i];
        owner_data_s  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        owner_valid_s = owner_valid_s;
      end
    end
    if (state_r == GRANT && !fifo_full) begin
      req_ready = grant_r;
    end else begin
      req_ready = '0;
    end
    fifo_wr_en = (state_r == GRANT) && owner_valid_s && !fifo_full;
    if (fifo_wr_en) begin
      fifo_wr_data = owner_data_s;
    end else begin
      fifo_wr_data = '0;
    end
    last_beat_s = (beat_cnt_r == CNT_W'(BURST_LEN - 1));
    if (owner_r == PTR_W'(NUM_REQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = owner_r + PTR_W'(1);
    end
  end

  // Arbitration state machine: grant, burst counting and release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      owner_r    <= '0;
      rr_ptr_r   <= '0;
      beat_cnt_r <= '0;
      grant_r    <= '0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            state_r    <= GRANT;
            owner_r    <= pick_idx_s;
            beat_cnt_r <= '0;
            grant_r    <= to_onehot(pick_idx_s);
            busy_r     <= 1'b1;
          end else begin
            grant_r <= '0;
            busy_r  <= 1'b0;
          end
        end
        GRANT: begin
          if (!owner_valid_s || (fifo_wr_en && last_beat_s)) begin
            state_r    <= IDLE;
            rr_ptr_r   <= next_ptr_s;
            beat_cnt_r <= '0;
            grant_r    <= '0;
            busy_r     <= 1'b0;
          end else if (fifo_wr_en) begin
            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
          end else begin
            beat_cnt_r <= beat_cnt_r;
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign grant = grant_r;
  assign busy  = busy_r;

endmodule
